cpu: RTL and testbench

- Minimal 8-bit accumulator CPU (SAP-1/2 class) with one shared 16x8 program/data RAM.
- Datapath: PC, MAR, IR, A, B, OUT, ALU and a flags register, sequenced by a fixed-length T-state controller.
- Top-level block of the design; `out_val` drives the display and the flag outputs drive status LEDs.

---
 rtl/cpu.sv | 235 +++++++++++++++++++++++
 tb/tb_cpu.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// cpu: 8-bit accumulator CPU with six T-states per instruction and a shared 16x8 program/data RAM.
// Optional: define CPU_JN_EN to make opcode 9 a jump-if-negative (JN); otherwise opcode 9 is a NOP.
module cpu_register #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] latched_data
);
    logic [W-1:0] data_q, data_d;

    // Next value: load or hold.
    always_comb begin
        if (load) data_d = d;
        else      data_d = data_q;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= {W{1'b0}};
        else        data_q <= data_d;
    end

    assign latched_data = data_q;
endmodule

module cpu_program_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] d,
    output logic [W-1:0] counter_out
);
    logic [W-1:0] pc_q, pc_d;

    // Next PC: jump target, increment (natural wrap), or hold.
    always_comb begin
        if (load)     pc_d = d;
        else if (inc) pc_d = pc_q + {{(W-1){1'b0}}, 1'b1};
        else          pc_d = pc_q;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= {W{1'b0}};
        else        pc_q <= pc_d;
    end

    assign counter_out = pc_q;
endmodule

module cpu_ram #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    // Contents survive reset; they are loaded from outside before the first run.
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

module cpu #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] out_val,
    output logic                  flag_zero_o,
    output logic                  flag_carry_o,
    output logic                  flag_negative_o
);
    typedef enum logic [2:0] {
        T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, T5 = 3'd5
    } tstate_e;

    localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9, OP_OUT = 4'hE, OP_HLT = 4'hF;

    tstate_e               tstate_q, tstate_d;
    logic [ADDR_WIDTH-1:0] mar_q, mar_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic                  z_q, z_d, c_q, c_d, n_q, n_d;
    logic                  halt_q, halt_d;
    logic                  halt;

    logic [DATA_WIDTH-1:0] a_val, b_val, a_next, ram_rdata;
    logic [ADDR_WIDTH-1:0] pc_val;
    logic [3:0]            opcode, operand;
    logic [DATA_WIDTH:0]   alu_res;
    logic                  a_load, b_load, out_load, pc_load, pc_inc, ram_we, jn_taken;

    assign opcode  = ir_q[7:4];
    assign operand = ir_q[3:0];
    assign halt    = halt_q;

    // ALU: subtraction is A + ~B + 1, so carry-out set means no borrow.
    always_comb begin
        if (opcode == OP_SUB)
            alu_res = {1'b0, a_val} + {1'b0, ~b_val} + {{DATA_WIDTH{1'b0}}, 1'b1};
        else
            alu_res = {1'b0, a_val} + {1'b0, b_val};
    end

`ifdef CPU_JN_EN
    assign jn_taken = (opcode == OP_JN) && n_q;
`else
    assign jn_taken = 1'b0;
`endif

    // T-state sequencer and datapath control; everything holds while halted.
    always_comb begin
        tstate_d = tstate_q;
        mar_d    = mar_q;
        ir_d     = ir_q;
        z_d      = z_q;
        c_d      = c_q;
        n_d      = n_q;
        halt_d   = halt_q;
        a_load   = 1'b0;
        a_next   = alu_res[DATA_WIDTH-1:0];
        b_load   = 1'b0;
        out_load = 1'b0;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        ram_we   = 1'b0;
        if (!halt) begin
            case (tstate_q)
                T0: begin tstate_d = T1; mar_d = pc_val; end
                T1: begin tstate_d = T2; ir_d = ram_rdata; pc_inc = 1'b1; end
                T2: begin
                    tstate_d = T3;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_d = operand;
                        OP_LDI: begin
                            a_load = 1'b1;
                            a_next = {4'b0000, operand};
                            z_d    = (operand == 4'h0);
                            n_d    = 1'b0;
                            c_d    = 1'b0;
                        end
                        OP_JMP:  pc_load = 1'b1;
                        OP_JC:   pc_load = c_q;
                        OP_JZ:   pc_load = z_q;
                        OP_OUT:  out_load = 1'b1;
                        OP_HLT:  halt_d = 1'b1;
                        default: pc_load = jn_taken;
                    endcase
                end
                T3: begin
                    tstate_d = T4;
                    case (opcode)
                        OP_LDA: begin
                            a_load = 1'b1;
                            a_next = ram_rdata;
                            z_d    = (ram_rdata == 8'h00);
                            n_d    = ram_rdata[7];
                            c_d    = 1'b0;
                        end
                        OP_ADD, OP_SUB: b_load = 1'b1;
                        OP_STA:         ram_we = 1'b1;
                        default:        ;
                    endcase
                end
                T4: begin
                    tstate_d = T5;
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        a_load = 1'b1;
                        z_d    = (alu_res[DATA_WIDTH-1:0] == 8'h00);
                        n_d    = alu_res[DATA_WIDTH-1];
                        c_d    = alu_res[DATA_WIDTH];
                    end else begin
                        a_load = 1'b0;
                    end
                end
                default: tstate_d = T0;
            endcase
        end else begin
            tstate_d = tstate_q;
        end
    end

    // Controller and flag state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tstate_q <= T0;
            mar_q    <= {ADDR_WIDTH{1'b0}};
            ir_q     <= {DATA_WIDTH{1'b0}};
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            mar_q    <= mar_d;
            ir_q     <= ir_d;
            z_q      <= z_d;
            c_q      <= c_d;
            n_q      <= n_d;
            halt_q   <= halt_d;
        end
    end

    cpu_register #(.W(DATA_WIDTH)) u_register_A (
        .clk(clk), .rst_n(reset), .load(a_load), .d(a_next), .latched_data(a_val));
    cpu_register #(.W(DATA_WIDTH)) u_register_B (
        .clk(clk), .rst_n(reset), .load(b_load), .d(ram_rdata), .latched_data(b_val));
    cpu_register #(.W(DATA_WIDTH)) u_register_OUT (
        .clk(clk), .rst_n(reset), .load(out_load), .d(a_val), .latched_data(out_val));
    cpu_program_counter #(.W(ADDR_WIDTH)) u_program_counter (
        .clk(clk), .rst_n(reset), .load(pc_load), .inc(pc_inc), .d(operand), .counter_out(pc_val));
    cpu_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_ram (
        .clk(clk), .we(ram_we), .addr(mar_q), .wdata(a_val), .rdata(ram_rdata));

    assign flag_zero_o     = z_q;
    assign flag_carry_o    = c_q;
    assign flag_negative_o = n_q;
endmodule

// File: tb/tb_cpu.sv
// Directed table-driven bench for the accumulator CPU: two preloaded programs plus reset corner cases.
module tb_cpu;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] out_val;
    logic       fz, fc, fn;
    int         checks = 0;
    int         failures = 0;
    int         edges = 0;

    cpu dut (
        .clk(clk), .reset(reset), .out_val(out_val),
        .flag_zero_o(fz), .flag_carry_o(fc), .flag_negative_o(fn)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         prog;
        int         edge_n;
        logic [7:0] a, b, o;
        logic [3:0] pc;
        logic       z, c, n, h;
    } vec_t;

    vec_t tbl[$];

    logic [7:0] img0 [16] = '{8'h1F, 8'h2E, 8'h76, 8'h00, 8'h00, 8'h00, 8'h51, 8'h7A,
                              8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF};
    logic [7:0] img1 [16] = '{8'h55, 8'h3E, 8'h85, 8'h00, 8'h00, 8'h4D, 8'h3F, 8'hE0,
                              8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h05, 8'h01};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp);
        end
    endtask

    task automatic add(input int p, input int e, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] o, input logic [3:0] pc,
                       input logic z, input logic c, input logic n, input logic h);
        vec_t v;
        v.prog = p; v.edge_n = e; v.a = a; v.b = b; v.o = o; v.pc = pc;
        v.z = z; v.c = c; v.n = n; v.h = h;
        tbl.push_back(v);
    endtask

    task automatic check_state(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] o, input logic [3:0] pc,
                               input logic z, input logic c, input logic n, input logic h);
        chk({tag, "_A"},    dut.u_register_A.latched_data, a);
        chk({tag, "_B"},    dut.u_register_B.latched_data, b);
        chk({tag, "_OUTr"}, dut.u_register_OUT.latched_data, o);
        chk({tag, "_out"},  out_val, o);
        chk({tag, "_PC"},   {4'h0, dut.u_program_counter.counter_out}, {4'h0, pc});
        chk({tag, "_Z"},    {7'd0, fz}, {7'd0, z});
        chk({tag, "_C"},    {7'd0, fc}, {7'd0, c});
        chk({tag, "_N"},    {7'd0, fn}, {7'd0, n});
        chk({tag, "_halt"}, {7'd0, dut.halt}, {7'd0, h});
    endtask

    task automatic load_prog(input int p);
        for (int i = 0; i < 16; i++)
            dut.u_ram.mem[i] = (p == 0) ? img0[i] : img1[i];
    endtask

    task automatic advance_to(input int target);
        while (edges < target) begin
            @(posedge clk);
            edges++;
        end
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        edges = 0;
    endtask

    task automatic run_table(input int p);
        foreach (tbl[k]) begin
            if (tbl[k].prog == p) begin
                advance_to(tbl[k].edge_n);
                check_state($sformatf("p%0d_e%0d", p, tbl[k].edge_n), tbl[k].a, tbl[k].b,
                            tbl[k].o, tbl[k].pc, tbl[k].z, tbl[k].c, tbl[k].n, tbl[k].h);
            end
        end
    endtask

    initial begin
        //   prog edge  A      B      OUT    PC    Z     C     N     halt
        add(0,  2, 8'h00, 8'h00, 8'h00, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(0,  4, 8'hFF, 8'h00, 8'h00, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(0,  6, 8'hFF, 8'h00, 8'h00, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(0, 10, 8'hFF, 8'h01, 8'h00, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0);
        add(0, 12, 8'h00, 8'h01, 8'h00, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0);
        add(0, 18, 8'h00, 8'h01, 8'h00, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0);
        add(0, 24, 8'h01, 8'h01, 8'h00, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
        add(0, 30, 8'h01, 8'h01, 8'h00, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0);
        add(0, 36, 8'h01, 8'h01, 8'h01, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
        add(0, 39, 8'h01, 8'h01, 8'h01, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1);
        add(0, 89, 8'h01, 8'h01, 8'h01, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1,  6, 8'h05, 8'h00, 8'h00, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1, 12, 8'h00, 8'h05, 8'h00, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1, 18, 8'h00, 8'h05, 8'h00, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1, 24, 8'h00, 8'h05, 8'h00, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1, 30, 8'hFF, 8'h01, 8'h00, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1, 36, 8'hFF, 8'h01, 8'hFF, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1, 39, 8'hFF, 8'h01, 8'hFF, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1);
        add(1, 60, 8'hFF, 8'h01, 8'hFF, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1);

        // Power-on reset held across clock edges.
        reset = 1'b0;
        load_prog(0);
        repeat (2) @(posedge clk);
        #1;
        check_state("por", 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        release_reset();
        run_table(0);

        // Asynchronous reset out of halt: takes effect with no clock edge; RAM untouched.
        reset = 1'b0;
        #1;
        check_state("rst_halt", 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            chk($sformatf("ram_keep_%0d", i), dut.u_ram.mem[i], img0[i]);
        release_reset();

        // Reset in the middle of ADD, then the program must re-run identically.
        advance_to(9);
        check_state("mid_add_pre", 8'hFF, 8'h00, 8'h00, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check_state("mid_add_rst", 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        release_reset();
        run_table(0);

        // Second program: SUB, JZ, STA, borrow on SUB, OUTA of a negative value.
        reset = 1'b0;
        #1;
        load_prog(1);
        release_reset();
        run_table(1);
        chk("sta_mem_D", dut.u_ram.mem[13], 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
